// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit unit.
// UART_TX_PARITY_EN adds the even-parity state to tx_state_t.
package uart_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int BRD_W      = 16;
    localparam logic [BRD_W-1:0] BRD_MIN = 16'd1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
        , ST_PARITY = 3'd4
`endif
    } tx_state_t;

    // A zero divisor would never produce a bit_done, so it is clamped to one clock.
    function automatic logic [BRD_W-1:0] eff_brd(input logic [BRD_W-1:0] b);
        return (b == '0) ? BRD_MIN : b;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: r_cnt runs 0..brd_q-1 and bit_done marks the last clock of each bit.
// Held at zero while clr is high so every frame starts on a fresh period.
module uart_baud_gen
    import uart_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [BRD_W-1:0] brd_q,
    output logic             bit_done
);

    logic [BRD_W-1:0] r_cnt;

    assign bit_done = !clr && (r_cnt == (brd_q - BRD_MIN));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (clr || bit_done) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + BRD_MIN;
        end
    end

endmodule

// File: rtl/uart_tx_unit.sv
// UART transmit unit: byte FIFO fed by the LSU and an 8N1 serialiser with a latched divisor.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and stop.
module uart_tx_unit
    import uart_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] uart_in,
    input  logic              get,
    input  logic [BRD_W-1:0]  brd,
    output logic              Ff,
    output logic              Fe,
    output logic              tx,
    output logic              tx_busy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    tx_state_t         r_state;
    logic [DATA_W-1:0] r_shift;
    logic [IDX_W-1:0]  r_bit_idx;
    logic [BRD_W-1:0]  r_brd_q;
`ifdef UART_TX_PARITY_EN
    logic              r_parity;
`endif

    logic              w_push;
    logic              w_pop;
    logic              w_bit_done;
    logic              w_baud_clr;
    logic [CNT_W-1:0]  w_count_nxt;
    logic [DATA_W-1:0] w_shift_nxt;
    logic [DATA_W-1:0] w_head;

    // Push legality uses the registered Ff, so a pop on the same edge does not open a slot.
    assign w_push      = get && !Ff;
    assign w_pop       = (r_state == ST_IDLE) && !Fe;
    assign w_baud_clr  = (r_state == ST_IDLE);
    assign w_shift_nxt = r_shift >> 1;
    assign w_head      = r_mem[r_rd_ptr];

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CNT_ONE;
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= uart_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            Ff       <= 1'b0;
            Fe       <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            r_count <= w_count_nxt;
            Ff      <= (w_count_nxt == CNT_FULL);
            Fe      <= (w_count_nxt == '0);
        end
    end

    uart_baud_gen u_baud (
        .clk      (clk),
        .rst      (rst),
        .clr      (w_baud_clr),
        .brd_q    (r_brd_q),
        .bit_done (w_bit_done)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            tx        <= 1'b1;
            tx_busy   <= 1'b0;
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_brd_q   <= BRD_MIN;
`ifdef UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    tx      <= 1'b1;
                    tx_busy <= 1'b0;
                    if (w_pop) begin
                        r_state <= ST_START;
                        tx      <= 1'b0;
                        tx_busy <= 1'b1;
                        r_shift <= w_head;
                        r_brd_q <= eff_brd(brd);
`ifdef UART_TX_PARITY_EN
                        r_parity <= ^w_head;
`endif
                    end
                end
                ST_START: begin
                    if (w_bit_done) begin
                        r_state   <= ST_DATA;
                        tx        <= r_shift[0];
                        r_bit_idx <= '0;
                    end
                end
                ST_DATA: begin
                    if (w_bit_done) begin
                        if (r_bit_idx == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                            r_state <= ST_PARITY;
                            tx      <= r_parity;
`else
                            r_state <= ST_STOP;
                            tx      <= 1'b1;
`endif
                        end else begin
                            r_shift   <= w_shift_nxt;
                            tx        <= w_shift_nxt[0];
                            r_bit_idx <= r_bit_idx + IDX_ONE;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (w_bit_done) begin
                        r_state <= ST_STOP;
                        tx      <= 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (w_bit_done) begin
                        r_state <= ST_IDLE;
                        tx_busy <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    tx      <= 1'b1;
                    tx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_unit.sv
// Directed bench for uart_tx_unit: frame shape, FIFO full/empty, divisor handling, reset abort.
// Build with UART_TX_PARITY_EN to also exercise the parity frame.
module tb_uart_tx_unit;
    import uart_pkg::*;

`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [7:0]       uart_in = 8'h00;
    logic             get = 1'b0;
    logic [BRD_W-1:0] brd = 16'd4;
    logic             Ff;
    logic             Fe;
    logic             tx;
    logic             tx_busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    uart_tx_unit #(.DEPTH(8), .DATA_W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .uart_in (uart_in),
        .get     (get),
        .brd     (brd),
        .Ff      (Ff),
        .Fe      (Fe),
        .tx      (tx),
        .tx_busy (tx_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called and returns at a negedge; the byte is presented for exactly one rising edge.
    task automatic write_byte(input logic [7:0] b);
        get     = 1'b1;
        uart_in = b;
        @(negedge clk);
        get     = 1'b0;
    endtask

    // Waits for the start bit, checks every clock of the frame against the expected bit
    // pattern, and returns on the IDLE clock that follows the stop bit.
    task automatic rx_frame(input string tag, input int b, input logic [7:0] exp,
                            output int start_cyc);
        int         budget = 0;
        int         errs   = 0;
        logic [7:0] d      = 8'h00;
        logic       e;
        while (tx !== 1'b0 && budget < 3000) begin
            @(negedge clk);
            budget++;
        end
        start_cyc = cyc;
        if (tx !== 1'b0) begin
            chk({tag, "_timeout"}, 32'd1, 32'd0);
        end else begin
            for (int s = 0; s < 10 + PAR; s++) begin
                if (s == 0)                  e = 1'b0;
                else if (s <= 8)             e = exp[s-1];
                else if (s == 9 && PAR == 1) e = ^exp;
                else                         e = 1'b1;
                for (int k = 0; k < b; k++) begin
                    if (tx !== e || tx_busy !== 1'b1) errs++;
                    if (s >= 1 && s <= 8 && k == b / 2) d[s-1] = tx;
                    @(negedge clk);
                end
            end
            if (tx !== 1'b1 || tx_busy !== 1'b0) errs++;
            chk({tag, "_data"}, {24'h0, d}, {24'h0, exp});
            chk({tag, "_shape"}, errs, 0);
            chk({tag, "_len"}, cyc - start_cyc, (10 + PAR) * b);
        end
    endtask

    task automatic quiet_tail(input string tag, input int n);
        int lows = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || tx_busy !== 1'b0) lows++;
        end
        chk({tag, "_quiet"}, lows, 0);
        chk({tag, "_fe"}, {31'h0, Fe}, 32'd1);
    endtask

    initial begin
        int s1, s2, s3;

        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_fe", {31'h0, Fe}, 32'd1);
        chk("rst_ff", {31'h0, Ff}, 32'd0);
        chk("rst_tx", {31'h0, tx}, 32'd1);
        chk("rst_busy", {31'h0, tx_busy}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Single byte, latency and empty-flag sequence.
        brd = 16'd4;
        write_byte(8'hA5);
        chk("t1_fe_after_push", {31'h0, Fe}, 32'd0);
        chk("t1_tx_still_idle", {31'h0, tx}, 32'd1);
        @(negedge clk);
        chk("t1_tx_start", {31'h0, tx}, 32'd0);
        chk("t1_fe_after_pop", {31'h0, Fe}, 32'd1);
        chk("t1_busy", {31'h0, tx_busy}, 32'd1);
        rx_frame("t1", 4, 8'hA5, s1);

        // Nine back-to-back writes fill the FIFO (first byte popped at once), tenth dropped.
        brd = 16'd16;
        fork
            begin
                for (int i = 0; i < 9; i++) write_byte(8'h30 + 8'(i));
                chk("t2_ff_full", {31'h0, Ff}, 32'd1);
                write_byte(8'hEE);
                chk("t2_ff_after_drop", {31'h0, Ff}, 32'd1);
                chk("t2_fe_after_drop", {31'h0, Fe}, 32'd0);
            end
            begin
                for (int i = 0; i < 9; i++) rx_frame($sformatf("t2_f%0d", i), 16, 8'h30 + 8'(i), s1);
            end
        join
        quiet_tail("t2", 40);

        // Zero divisor behaves as one clock per bit; back-to-back spacing is frame + 1 IDLE.
        brd = 16'd0;
        write_byte(8'hFF);
        write_byte(8'h5A);
        rx_frame("t3_a", 1, 8'hFF, s1);
        rx_frame("t3_b", 1, 8'h5A, s2);
        chk("t3_period", s2 - s1, 11 + PAR);

        // Divisor change mid-frame only takes effect on the next frame.
        brd = 16'd4;
        write_byte(8'h3C);
        write_byte(8'hC3);
        fork
            rx_frame("t4_a", 4, 8'h3C, s1);
            begin
                repeat (10) @(negedge clk);
                brd = 16'd8;
            end
        join
        rx_frame("t4_b", 8, 8'hC3, s2);
        chk("t4_period", s2 - s1, 4 * (10 + PAR) + 1);

        // Reset during DATA bit 3 aborts the frame and discards queued bytes.
        brd = 16'd4;
        write_byte(8'hF7);
        write_byte(8'h81);
        write_byte(8'h42);
        repeat (16) @(negedge clk);
        chk("t5_pre_bit3", {30'h0, tx, tx_busy}, 32'h1);
        rst = 1'b0;
        @(negedge clk);
        chk("t5_tx", {31'h0, tx}, 32'd1);
        chk("t5_fe", {31'h0, Fe}, 32'd1);
        chk("t5_busy", {31'h0, tx_busy}, 32'd0);
        chk("t5_ff", {31'h0, Ff}, 32'd0);
        rst = 1'b1;
        quiet_tail("t5", 60);

`ifdef UART_TX_PARITY_EN
        // Even parity of 8'h07 is 1; frame is 11 bits of 2 clocks.
        brd = 16'd2;
        write_byte(8'h07);
        rx_frame("t6", 2, 8'h07, s3);
`else
        s3 = 0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
